alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Pipelined 8-bit ALU; the DUT driven by the ALU UVM interface. Takes operations on a
//  valid/ready request channel and returns 16-bit results in order on a valid/ready
//  response channel. A response FIFO absorbs backpressure. Requests never drop.
// PARAMETERS
//  FIFO_DEPTH  4  response FIFO entries; power of 2, >= 2; bounds outstanding ops
// PORTS
//  clk          in   1   sole clock, rising edge
//  rst_n        in   1   reset, asynchronous assert, active-low
//  req_valid    in   1   request present
//  req_ready    out  1   block can accept a request this cycle
//  req_op       in   3   opcode (alu_op_e)
//  req_op1      in   8   operand 1, unsigned
//  req_op2      in   8   operand 2, unsigned
//  resp_valid   out  1   result present at FIFO head
//  resp_ready   in   1   consumer accepts result
//  resp_result  out  16  result
// BEHAVIOUR
//  - Reset (rst_n=0, async): all valids/counters clear; req_ready=0 while in reset, 1 after;
//    resp_valid=0, resp_result=0. Reset mid-operation discards stage and FIFO contents.
//  - Accept when req_valid&&req_ready at edge t. Result is written to stage register at t,
//    pushed to FIFO at t+1, and resp_valid=1 after t+1 (min latency 2 clocks). One op/cycle.
//  - Pop on resp_valid&&resp_ready. resp_result/resp_valid must stay stable while
//    resp_valid&&!resp_ready. Results return strictly in acceptance order.
//  - Credit: occ = stage_valid + fifo_count; req_ready = (occ < FIFO_DEPTH), registered
//    state only. No combinational path from resp_ready to req_ready. A same-cycle pop
//    frees credit the following cycle.
//  - Full: occ==FIFO_DEPTH -> req_ready=0. Empty: resp_valid=0, resp_result holds last value.
//  - Simultaneous push+pop at full FIFO is legal. Pointers wrap modulo FIFO_DEPTH.
//  - Ops (operands zero-extended to 16b, result mod 2^16):
//    0 ADD op1+op2 | 1 SUB op1-op2 (two's complement, 3-5=16'hFFFE) | 2 MUL op1*op2
//    3 AND | 4 OR | 5 XOR (upper byte 0) | 6 SHL op1<<op2[3:0] | 7 SHR op1>>op2[2:0]
// CONFIGURATION
//  ALU_STATS_EN defined: adds outputs stat_req_cnt[15:0] and stat_resp_cnt[15:0].
//    stat_req_cnt counts accepted requests. stat_resp_cnt counts popped responses.
//    Both reset to 0, wrap at 2^16, and update on the handshake edge.
//  ALU_STATS_EN undefined: neither port nor counter exists. Datapath is identical.
// STRUCTURE
//  alu_pkg: typedef enum logic [2:0] alu_op_e {ALU_ADD..ALU_SHR}; ALU_OPW=8, ALU_RESW=16;
//    function alu_compute(op, a, b) returning 16b, shared with the scoreboard model.
//  Sub-module alu_resp_fifo (DATA_W, DEPTH): sync FIFO with push, pop, count, head data.
//  Top: accept logic, compute-to-stage register, credit compare, optional stats.
// TESTING
//  1 Reset then single ADD 8'hFF+8'h01, resp_ready=1 -> 16'h0100, resp_valid 2 clks after accept.
//  2 SUB 3-5, MUL 255*255, SHL 1<<op2=15, SHR 8'h80>>op2=7 -> FFFE, FE01, 8000, 0001.
//  3 resp_ready=0, stream 6 ADDs (DEPTH 4) -> exactly 4 accepted, req_ready=0. Release
//    resp_ready -> remaining 2 accepted, all 6 returned in order.
//  4 resp_ready toggled randomly, req_valid held -> resp_result stable while stalled,
//    no loss or duplication over 1000 ops, checked against alu_compute.
//  5 rst_n pulsed low with 3 ops outstanding -> resp_valid=0 immediately.
//    After release: no stale response, new op returns correct result.
//  6 ALU_STATS_EN build, 10 accepted / 7 popped -> stat_req_cnt=10, stat_resp_cnt=7.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcode enum, datapath widths and the shared ALU compute function.
// Rev 1.0
// ============================================================================
package alu_pkg;

  localparam int ALU_OPW  = 8;
  localparam int ALU_RESW = 16;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;

  // Operands are zero-extended; every result wraps modulo 2^16.
  function automatic logic [ALU_RESW-1:0] alu_compute(
    input alu_op_e              op,
    input logic [ALU_OPW-1:0]   a,
    input logic [ALU_OPW-1:0]   b
  );
    logic [ALU_RESW-1:0] ea;
    logic [ALU_RESW-1:0] eb;
    logic [ALU_RESW-1:0] r;
    ea = {{(ALU_RESW-ALU_OPW){1'b0}}, a};
    eb = {{(ALU_RESW-ALU_OPW){1'b0}}, b};
    r  = '0;
    case (op)
      ALU_ADD: r = ea + eb;
      ALU_SUB: r = ea - eb;
      ALU_MUL: r = ea * eb;
      ALU_AND: r = ea & eb;
      ALU_OR:  r = ea | eb;
      ALU_XOR: r = ea ^ eb;
      ALU_SHL: r = ea << b[3:0];
      ALU_SHR: r = ea >> b[2:0];
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_resp_fifo.sv
`default_nettype none
// ============================================================================
// alu_resp_fifo : synchronous FIFO with push, pop, occupancy count and head data.
// Rev 1.0
// ============================================================================
module alu_resp_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_CNT_W-1:0] r_count;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// alu_pipe : pipelined 8-bit ALU, credit-gated request channel, response FIFO.
//   Define ALU_STATS_EN to add request/response handshake counters.
// Rev 1.0
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [ALU_OPW-1:0]  req_op1,
  input  logic [ALU_OPW-1:0]  req_op2,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [ALU_RESW-1:0] resp_result
`ifdef ALU_STATS_EN
  ,
  output logic [15:0]         stat_req_cnt,
  output logic [15:0]         stat_resp_cnt
`endif
);

  localparam int               C_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [C_CNT_W:0] C_DEPTH = (C_CNT_W + 1)'(FIFO_DEPTH);

  logic                r_run;
  logic                r_stage_valid;
  logic [ALU_RESW-1:0] r_stage_data;
  logic [ALU_RESW-1:0] r_last_result;
  logic [C_CNT_W-1:0]  w_count;
  logic [C_CNT_W:0]    w_occ;
  logic [ALU_RESW-1:0] w_head;
  logic                w_accept;
  logic                w_pop;

  // Credit is derived from registered state only, so a pop frees a slot next cycle.
  assign w_occ       = {1'b0, w_count} + {{C_CNT_W{1'b0}}, r_stage_valid};
  assign req_ready   = r_run && (w_occ < C_DEPTH);
  assign w_accept    = req_valid && req_ready;
  assign resp_valid  = (w_count != '0);
  assign w_pop       = resp_valid && resp_ready;
  assign resp_result = resp_valid ? w_head : r_last_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_stage_valid <= 1'b0;
      r_stage_data  <= '0;
      r_last_result <= '0;
    end else begin
      r_run         <= 1'b1;
      r_stage_valid <= w_accept;
      if (w_accept) r_stage_data <= alu_compute(alu_op_e'(req_op), req_op1, req_op2);
      if (w_pop)    r_last_result <= w_head;
    end
  end

  alu_resp_fifo #(
    .DATA_W (ALU_RESW),
    .DEPTH  (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (r_stage_valid),
    .push_data (r_stage_data),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (w_count)
  );

`ifdef ALU_STATS_EN
  logic [15:0] r_stat_req;
  logic [15:0] r_stat_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_req  <= '0;
      r_stat_resp <= '0;
    end else begin
      if (w_accept) r_stat_req  <= r_stat_req + 16'd1;
      if (w_pop)    r_stat_resp <= r_stat_resp + 16'd1;
    end
  end

  assign stat_req_cnt  = r_stat_req;
  assign stat_resp_cnt = r_stat_resp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// tb_alu_pipe : randomized self-checking bench for alu_pipe with an in-order
//   scoreboard fed by an arithmetic reference model.
// Rev 1.0
// ============================================================================
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        resp_ready = 1'b0;
  logic [2:0]  req_op = '0;
  logic [7:0]  req_op1 = '0;
  logic [7:0]  req_op2 = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_result;
`ifdef ALU_STATS_EN
  logic [15:0] stat_req_cnt;
  logic [15:0] stat_resp_cnt;
`endif

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  bit          last_acc = 1'b0;
  int          n_acc = 0;
  int          n_pop = 0;

  always #5 clk = ~clk;

  alu_pipe #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result)
`ifdef ALU_STATS_EN
    ,
    .stat_req_cnt  (stat_req_cnt),
    .stat_resp_cnt (stat_resp_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, shifts as multiply/divide by powers of two.
  function automatic logic [15:0] ref_calc(input int op, input int a, input int b);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a * b;
      3:       r = a & b;
      4:       r = a | b;
      5:       r = a ^ b;
      6:       r = a * (1 << (b % 16));
      7:       r = a / (1 << (b % 8));
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  // One clock: observe at the falling edge, then return 1ns after the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_resp", {31'b0, resp_valid}, 32'd0);
      end else begin
        chk("resp_data", {16'b0, resp_result}, {16'b0, exp_q[0]});
        if (resp_ready) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
    last_acc = req_valid && req_ready;
    if (last_acc) begin
      exp_q.push_back(ref_calc(int'(req_op), int'(req_op1), int'(req_op2)));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int op, input int a, input int b);
    int guard = 0;
    req_valid = 1'b1;
    req_op    = op[2:0];
    req_op1   = a[7:0];
    req_op2   = b[7:0];
    do begin
      cycle();
      guard++;
    end while (!last_acc && guard < 200);
    chk("send_accept", {31'b0, last_acc}, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    resp_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 200) begin
      cycle();
      guard++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int k;
    int guard;
    int pop0;
    int ops3 [6];

    // Reset values
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_result", {16'b0, resp_result}, 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // 1: single ADD latency
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_op     = 3'd0;
    req_op1    = 8'hFF;
    req_op2    = 8'h01;
    @(negedge clk);
    chk("t1_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid_t", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("t1_valid_t1", {31'b0, resp_valid}, 32'd1);
    chk("t1_result", {16'b0, resp_result}, 32'h0100);
    @(negedge clk);
    chk("t1_empty", {31'b0, resp_valid}, 32'd0);
    chk("t1_hold", {16'b0, resp_result}, 32'h0100);
    @(posedge clk); #1;

    // 2: directed corner ops through the scoreboard
    send(1, 3, 5);
    send(2, 255, 255);
    send(6, 1, 15);
    send(7, 8'h80, 7);
    send(5, 8'hA5, 8'hFF);
    drain();

    // 3: backpressure at full FIFO
    ops3 = '{11, 22, 33, 44, 55, 66};
    pop0 = n_pop;
    resp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid = (k < 6);
      if (k < 6) begin
        req_op  = 3'd0;
        req_op1 = ops3[k][7:0];
        req_op2 = 8'd200;
      end
      cycle();
      if (last_acc) k++;
    end
    chk("t3_accepted", k, 32'd4);
    chk("t3_ready_low", {31'b0, req_ready}, 32'd0);
    resp_ready = 1'b1;
    guard = 0;
    while (k < 6 && guard < 50) begin
      req_valid = 1'b1;
      req_op    = 3'd0;
      req_op1   = ops3[k][7:0];
      req_op2   = 8'd200;
      cycle();
      if (last_acc) k++;
      guard++;
    end
    req_valid = 1'b0;
    drain();
    chk("t3_returned", n_pop - pop0, 32'd6);

    // 4: random ops with random backpressure
    pop0  = n_pop;
    k     = 0;
    guard = 0;
    while (k < 1000 && guard < 20000) begin
      if (!req_valid) begin
        req_valid = 1'b1;
        req_op    = 3'($urandom_range(0, 7));
        req_op1   = 8'($urandom);
        req_op2   = 8'($urandom);
      end
      resp_ready = 1'($urandom_range(0, 1));
      cycle();
      if (last_acc) begin
        k++;
        req_valid = 1'b0;
      end
      guard++;
    end
    req_valid = 1'b0;
    chk("t4_sent", k, 32'd1000);
    drain();
    chk("t4_returned", n_pop - pop0, 32'd1000);

    // 5: reset with ops outstanding
    resp_ready = 1'b0;
    send(2, 7, 9);
    send(0, 1, 2);
    send(4, 8'h0F, 8'hF0);
    rst_n = 1'b0;
    #1;
    chk("t5_valid_in_rst", {31'b0, resp_valid}, 32'd0);
    chk("t5_ready_in_rst", {31'b0, req_ready}, 32'd0);
    chk("t5_result_in_rst", {16'b0, resp_result}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    chk("t5_no_stale", {31'b0, resp_valid}, 32'd0);
    send(0, 8'h12, 8'h34);
    drain();

`ifdef ALU_STATS_EN
    // 6: statistics counters
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resp_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(i % 8, i + 3, i + 1);
    drain();
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(0, i, i);
    cycle();
    chk("t6_req_cnt", {16'b0, stat_req_cnt}, 32'd10);
    chk("t6_resp_cnt", {16'b0, stat_resp_cnt}, 32'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
